// File: rtl/rip_bp_update_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// rip_bp_update_scheduler_pkg
// Shared types for the branch predictor update scheduler.
//   TABLE_DEPTH    : log2 of predictor table entries
//   bp_index_t     : predictor table index
//   bp_weight_t    : 2-bit saturating counter state
//   sched_state_t  : scheduler FSM states (RUN, CLEAR, CLEAR_LAST)
//   BP_STAT_WIDTH  : width of the optional statistics counters
//   sched_entry_t  : one queued table write {index, weight, actual}
// The index/weight types mirror the predictor's own constants so both sides
// agree on field widths.
// ---------------------------------------------------------------------------
package rip_bp_update_scheduler_pkg;

  localparam int TABLE_DEPTH = 4;

  typedef logic [TABLE_DEPTH-1:0] bp_index_t;

  typedef enum logic [1:0] {
    STRONGLY_UNTAKEN = 2'b00,
    WEAKLY_UNTAKEN   = 2'b01,
    WEAKLY_TAKEN     = 2'b10,
    STRONGLY_TAKEN   = 2'b11
  } bp_weight_t;

  typedef enum logic [1:0] {
    RUN,
    CLEAR,
    CLEAR_LAST
  } sched_state_t;

  localparam int BP_STAT_WIDTH = 32;

  typedef struct packed {
    bp_index_t  index;
    bp_weight_t weight;
    logic       actual;
  } sched_entry_t;

endpackage

// File: rtl/rip_sync_fifo.sv
// ---------------------------------------------------------------------------
// rip_sync_fifo
// Small synchronous FIFO with flush. Pushes while full and pops while empty
// are ignored, so the caller never corrupts the pointers.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the FIFO at the next edge
//   push       : write push_data
//   pop        : advance past the head entry (pop_data)
//   full/empty : occupancy flags
//   count      : number of stored entries
// ---------------------------------------------------------------------------
module rip_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == DEPTH_C);
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/rip_bp_update_scheduler.sv
// ---------------------------------------------------------------------------
// rip_bp_update_scheduler
// Owns the predictor table's single update port. Queues resolved-branch
// updates and drains one per unstalled cycle, and runs a clear sweep that
// writes CLEAR_WEIGHT to every table entry after reset or on request.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : update handshake from execute
//   in_index/in_weight/in_actual : update payload
//   clear_req           : one-cycle request to sweep the table
//   clear_busy          : sweep in progress
//   clear_done          : one-cycle pulse at end of sweep
//   stall               : suppresses table writes
//   bp_update, bp_update_index, bp_update_weight, bp_actual : predictor port
//   fifo_count          : queued entries
// Optional macro RIP_BP_SCHED_STATS_EN adds saturating counters
//   stat_commit_cnt and stat_backpressure_cnt.
// ---------------------------------------------------------------------------
module rip_bp_update_scheduler
  import rip_bp_update_scheduler_pkg::*;
#(
  parameter int         FIFO_DEPTH     = 4,
  parameter bp_weight_t CLEAR_WEIGHT   = STRONGLY_UNTAKEN,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  bp_index_t                     in_index,
  input  bp_weight_t                    in_weight,
  input  logic                          in_actual,
  input  logic                          clear_req,
  output logic                          clear_busy,
  output logic                          clear_done,
  input  logic                          stall,
  output logic                          bp_update,
  output bp_index_t                     bp_update_index,
  output bp_weight_t                    bp_update_weight,
  output logic                          bp_actual,
`ifdef RIP_BP_SCHED_STATS_EN
  output logic [BP_STAT_WIDTH-1:0]      stat_commit_cnt,
  output logic [BP_STAT_WIDTH-1:0]      stat_backpressure_cnt,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam bp_index_t LAST_IDX = '1;

  sched_state_t state;
  sched_entry_t out_q;
  sched_entry_t fifo_head;
  sched_entry_t in_entry;
  logic         out_valid_q;
  bp_index_t    clr_idx;
  logic         clear_done_q;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;
  logic         flush;

  assign in_entry = {in_index, in_weight, in_actual};

  // Inputs are only taken in RUN, and never alongside a clear request so the
  // flush cannot race a fresh push.
  assign in_ready = (state == RUN) & ~fifo_full & ~clear_req;
  assign push     = in_valid & in_ready;
  assign pop      = (state == RUN) & ~clear_req & ~stall & ~fifo_empty;
  assign flush    = (state == RUN) & clear_req;

  rip_sync_fifo #(
    .WIDTH ($bits(sched_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (in_entry),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bp_update        = out_valid_q & ~stall;
  assign bp_update_index  = out_q.index;
  assign bp_update_weight = out_q.weight;
  assign bp_actual        = out_q.actual;
  assign clear_busy       = (state != RUN);
  assign clear_done       = clear_done_q;

  // FSM plus output register. The register only reloads when unstalled, so a
  // stalled write is presented unchanged until the predictor takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CLEAR_ON_RESET ? CLEAR : RUN;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      clr_idx      <= '0;
      clear_done_q <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      unique case (state)
        RUN: begin
          if (clear_req) begin
            state       <= CLEAR;
            out_valid_q <= 1'b0;
            clr_idx     <= '0;
          end else if (!stall) begin
            out_valid_q <= ~fifo_empty;
            if (!fifo_empty) out_q <= fifo_head;
          end
        end
        CLEAR: begin
          if (!stall) begin
            out_valid_q <= 1'b1;
            out_q       <= '{index: clr_idx, weight: CLEAR_WEIGHT, actual: 1'b0};
            // Hold idx at the last entry instead of wrapping.
            if (clr_idx == LAST_IDX) state <= CLEAR_LAST;
            else                     clr_idx <= clr_idx + 1'b1;
          end
        end
        CLEAR_LAST: begin
          if (!stall) begin
            out_valid_q  <= 1'b0;
            clear_done_q <= 1'b1;
            state        <= RUN;
          end
        end
        default: begin
          state       <= RUN;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef RIP_BP_SCHED_STATS_EN
  logic [BP_STAT_WIDTH-1:0] commit_q;
  logic [BP_STAT_WIDTH-1:0] backpressure_q;

  assign stat_commit_cnt       = commit_q;
  assign stat_backpressure_cnt = backpressure_q;

  // Only RUN-state traffic is counted; sweep writes are excluded.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_q       <= '0;
      backpressure_q <= '0;
    end else if (state == RUN) begin
      if (bp_update && (commit_q != '1))
        commit_q <= commit_q + 1'b1;
      if (in_valid && !in_ready && (backpressure_q != '1))
        backpressure_q <= backpressure_q + 1'b1;
    end
  end
`endif

endmodule
